// File: rtl/image_ram_writer.sv
// image_ram_writer
// Streams one frame of 12-bit pixels into an image RAM. A valid/ready
// handshake accepts pixels in raster order. Each accepted pixel is written one
// cycle later at address {y, x}.
// Optional build macro: IMAGE_RAM_WRITER_CHECKSUM_EN adds a 16-bit running sum
// of the pixels written in the current frame. Without the macro, checksum is
// tied to zero.
module image_ram_writer #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 192,
  parameter int X_BITS = 7,
  parameter int Y_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        pix_valid,
  input  logic [11:0] pix_data,
  output logic        pix_ready,
  output logic        wr_en,
  output logic [14:0] wr_addr,
  output logic [11:0] wr_data,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] checksum
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(IMG_W - 1);
  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(IMG_H - 1);

  state_t            state, state_next;
  logic [X_BITS-1:0] x, x_next;
  logic [Y_BITS-1:0] y, y_next;
  logic              xfer;

  // The abort cycle never accepts a pixel, so ready drops combinationally.
  assign pix_ready  = (state == WRITE) && !abort;
  assign xfer       = pix_valid && pix_ready;
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

  // State and raster counters register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments. All registers
    // then update together at the edge, with no ordering race between blocks.
    if (rst) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
    end else begin
      state <= state_next;
      x     <= x_next;
      y     <= y_next;
    end
  end

  // Next-state and raster counter advance. The counters wrap at the image
  // edges, so no address outside the image is ever formed.
  always_comb begin
    // NOTE: every output of this block gets a default first. A path that
    // leaves one unassigned would infer a latch.
    state_next = state;
    x_next     = x;
    y_next     = y;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          state_next = WRITE;
          x_next     = '0;
          y_next     = '0;
        end
      end
      WRITE: begin
        if (abort) begin
          state_next = IDLE;
          x_next     = '0;
          y_next     = '0;
        end else if (xfer) begin
          if (x == X_LAST) begin
            x_next = '0;
            if (y == Y_LAST) begin
              y_next     = '0;
              state_next = DONE;
            end else begin
              y_next = y + 1'b1;
            end
          end else begin
            x_next = x + 1'b1;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Write port register: one write per accepted pixel, one cycle later.
  always_ff @(posedge clk) begin
    // NOTE: these are plain datapath registers, not a memory array. They are
    // reset so the RAM port reads zero after reset. Reset also drops a write
    // that is still pending.
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= xfer;
      if (xfer) begin
        wr_addr <= {y, x};
        wr_data <= pix_data;
      end
    end
  end

`ifdef IMAGE_RAM_WRITER_CHECKSUM_EN
  logic [15:0] sum_q;

  // Running frame sum. It is updated at the same edge that raises wr_en, so
  // the total already includes the last pixel when frame_done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else if (state == IDLE && start && !abort) begin
      sum_q <= '0;
    end else if (xfer) begin
      sum_q <= sum_q + {4'b0000, pix_data};
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = 16'h0000;
`endif

endmodule
